// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 encodings and request-qualification helpers
// for the load/store unit.
package lsu_pkg;

    localparam int XLEN  = 32;
    localparam int LANES = XLEN / 8;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    // Access size is carried in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] a;
        case (f3[1:0])
            2'b01:   a = {off[1], 1'b0};
            2'b10:   a = 2'b00;
            default: a = off;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering.
// Forward path builds byte enables and lane-replicated store data.
// Reverse path shifts the memory word down and sign/zero-extends it.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]       fwd_funct3,
    input  logic [1:0]       fwd_off,
    input  logic [XLEN-1:0]  wdata,
    output logic [LANES-1:0] byte_en,
    output logic [XLEN-1:0]  wdata_rep,
    input  logic [2:0]       rev_funct3,
    input  logic [1:0]       rev_off,
    input  logic [XLEN-1:0]  dout,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] dout_sh;

    // Byte enables follow the access size; data is replicated so every lane carries it.
    always_comb begin
        byte_en   = '0;
        wdata_rep = '0;
        case (fwd_funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << fwd_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = 4'b0011 << {fwd_off[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            default: ;
        endcase
    end

    // Shift the addressed bytes to the bottom, then extend per load type.
    always_comb begin
        dout_sh = dout >> {rev_off, 3'b000};
        rdata   = '0;
        case (rev_funct3)
            F3_LB:   rdata = {{24{dout_sh[7]}}, dout_sh[7:0]};
            F3_LH:   rdata = {{16{dout_sh[15]}}, dout_sh[15:0]};
            F3_LW:   rdata = dout_sh;
            F3_LBU:  rdata = {24'h000000, dout_sh[7:0]};
            F3_LHU:  rdata = {16'h0000, dout_sh[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the RV32I execute stage to a byte-lane data memory.
// One request per handshake; all outputs registered.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses
// instead of forcing natural alignment).
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | memory strobe visible for exactly this cycle
// WAIT  | load outstanding, waiting for mem_dout_ready or timeout
// RESP  | resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_AMOUNT     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic                  mem_rd,
    output logic [RAM_AMOUNT-1:0] mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_dout_ready
);

    // Timeout is a down-counter loaded on WAIT entry; terminal count zero
    // marks the last WAIT cycle in which ready is still accepted.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t state, state_nx;

    logic                  lat_we;
    logic [2:0]            lat_funct3;
    logic [1:0]            lat_off;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic                  accept;

    logic                  req_legal;
    logic                  req_trap;
    logic [1:0]            req_off;

    logic [RAM_AMOUNT-1:0] fwd_be;
    logic [DATA_WIDTH-1:0] fwd_di;
    logic [DATA_WIDTH-1:0] rev_rdata;

    logic                  req_ready_nx;
    logic                  resp_valid_nx;
    logic                  resp_err_nx;
    logic [DATA_WIDTH-1:0] resp_rdata_nx;
    logic                  mem_we_nx;
    logic                  mem_rd_nx;
    logic [RAM_AMOUNT-1:0] mem_ctrl_nx;
    logic [DATA_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_di_nx;

    // Qualify the incoming request: legality, misalignment policy, effective lane offset.
    always_comb begin
        req_legal = f3_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        req_trap  = misaligned(req_funct3, req_addr[1:0]);
        req_off   = req_addr[1:0];
`else
        req_trap  = 1'b0;
        req_off   = align_off(req_funct3, req_addr[1:0]);
`endif
    end

    // Forward path uses the live request so strobes land in ISSUE; reverse uses the latched one.
    lsu_lane_align u_lane_align (
        .fwd_funct3 (req_funct3),
        .fwd_off    (req_off),
        .wdata      (req_wdata),
        .byte_en    (fwd_be),
        .wdata_rep  (fwd_di),
        .rev_funct3 (lat_funct3),
        .rev_off    (lat_off),
        .dout       (mem_dout),
        .rdata      (rev_rdata)
    );

    // Next-state and next-output logic; outputs are registered, so each value
    // here becomes visible in the cycle after the decision.
    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        cnt_nx        = cnt;
        req_ready_nx  = 1'b0;
        resp_valid_nx = 1'b0;
        resp_err_nx   = 1'b0;
        resp_rdata_nx = '0;
        mem_we_nx     = 1'b0;
        mem_rd_nx     = 1'b0;
        mem_ctrl_nx   = '0;
        mem_addr_nx   = '0;
        mem_di_nx     = '0;
        case (state)
            IDLE: begin
                req_ready_nx = 1'b1;
                if (req_valid && req_ready) begin
                    accept       = 1'b1;
                    req_ready_nx = 1'b0;
                    if (!req_legal || req_trap) begin
                        state_nx      = RESP;
                        resp_valid_nx = 1'b1;
                        resp_err_nx   = 1'b1;
                    end else begin
                        state_nx    = ISSUE;
                        mem_we_nx   = req_we;
                        mem_rd_nx   = !req_we;
                        mem_ctrl_nx = fwd_be;
                        mem_addr_nx = {req_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_di_nx   = req_we ? fwd_di : '0;
                    end
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_nx      = RESP;
                    resp_valid_nx = 1'b1;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (mem_dout_ready) begin
                    state_nx      = RESP;
                    resp_valid_nx = 1'b1;
                    resp_rdata_nx = rev_rdata;
                end else if (cnt == '0) begin
                    state_nx      = RESP;
                    resp_valid_nx = 1'b1;
                    resp_err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nx     = IDLE;
                req_ready_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, request latch, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_funct3 <= '0;
            lat_off    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_ctrl   <= '0;
            mem_addr   <= '0;
            mem_di     <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            if (accept) begin
                lat_we     <= req_we;
                lat_funct3 <= req_funct3;
                lat_off    <= req_off;
            end
            req_ready  <= req_ready_nx;
            resp_valid <= resp_valid_nx;
            resp_err   <= resp_err_nx;
            resp_rdata <= resp_rdata_nx;
            mem_we     <= mem_we_nx;
            mem_rd     <= mem_rd_nx;
            mem_ctrl   <= mem_ctrl_nx;
            mem_addr   <= mem_addr_nx;
            mem_di     <= mem_di_nx;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks of load_store_unit
// against a byte-array memory model.
module tb_load_store_unit;

    localparam int TMO  = 16;
    localparam int NCYC = 21;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic        mem_rd;
    logic [3:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_di;
    logic [31:0] mem_dout;
    logic        mem_dout_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_b [0:63];

    load_store_unit #(
        .DATA_WIDTH     (32),
        .RAM_AMOUNT     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_we         (mem_we),
        .mem_rd         (mem_rd),
        .mem_ctrl       (mem_ctrl),
        .mem_addr       (mem_addr),
        .mem_di         (mem_di),
        .mem_dout       (mem_dout),
        .mem_dout_ready (mem_dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [5:0] w;
        w = {a[5:2], 2'b00};
        return {mem_b[w + 6'd3], mem_b[w + 6'd2], mem_b[w + 6'd1], mem_b[w]};
    endfunction

    // One complete transaction: issue, play the memory side, check every observable.
    task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int k, input bit poke, input string tag,
                          output logic [31:0] o_rdata, output logic [3:0] o_ctrl,
                          output logic [31:0] o_di, output logic [31:0] o_maddr);
        bit          legal, mis, trap, junk, rr_bad, s_we, s_rd;
        int          size, exp_strobe, exp_resp, ready_at, n_strobe, strobe_cyc, n_resp, resp_cyc, w;
        logic [31:0] ea, exp_rdata, exp_di, val, word;
        logic [3:0]  exp_ctrl;
        logic        exp_err, o_err;

        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        mis   = legal && ((int'(addr[1:0]) % size) != 0);
        trap  = mis && TRAP;
        ea = addr; exp_ctrl = '0; exp_di = '0; val = '0; word = '0;
        if (legal) begin
            ea       = addr - 32'(int'(addr[1:0]) % size);
            exp_ctrl = 4'(((32'd1 << size) - 32'd1) << ea[1:0]);
            if (size == 1)      exp_di = {24'h0, wd[7:0]} * 32'h01010101;
            else if (size == 2) exp_di = {16'h0, wd[15:0]} * 32'h00010001;
            else                exp_di = wd;
            for (int i = 0; i < size; i++)
                val = val | (32'(mem_b[ea[5:0] + 6'(i)]) << (8 * i));
            if (size < 4 && !f3[2] && val[8 * size - 1])
                val = val | ~((32'd1 << (8 * size)) - 32'd1);
            word = model_word(ea);
        end

        exp_strobe = 0; exp_err = 1'b0; exp_rdata = '0; ready_at = -1;
        if (!legal || trap) begin
            exp_resp = 1; exp_err = 1'b1;
        end else if (we) begin
            exp_strobe = 1; exp_resp = 2;
        end else begin
            exp_strobe = 1;
            ready_at   = 2 + k;
            if (k < TMO) begin exp_resp = 3 + k; exp_rdata = val; end
            else begin exp_resp = 2 + TMO; exp_err = 1'b1; end
        end

        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        chk({tag, ":ready_before"}, 32'(req_ready), 32'd1);

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_dout_ready = 1'b0;
        junk = 1'($urandom_range(0, 1));
        n_strobe = 0; strobe_cyc = -1; n_resp = 0; resp_cyc = -1; rr_bad = 1'b0;
        s_we = 1'b0; s_rd = 1'b0; o_err = 1'b0;
        o_rdata = '0; o_ctrl = '0; o_di = '0; o_maddr = '0;

        for (int c = 1; c <= NCYC; c++) begin
            @(negedge clk);
            if (mem_we || mem_rd) begin
                n_strobe++; strobe_cyc = c; s_we = mem_we; s_rd = mem_rd;
                o_ctrl = mem_ctrl; o_maddr = mem_addr; o_di = mem_di;
            end
            if (resp_valid) begin
                n_resp++; resp_cyc = c; o_rdata = resp_rdata; o_err = resp_err;
            end
            if (req_ready !== (c > exp_resp)) rr_bad = 1'b1;
            req_valid = poke && (c < exp_resp);
            if (poke) begin
                req_we = 1'b1; req_funct3 = 3'd2;
                req_addr = $urandom & 32'hFFFF_FFC0; req_wdata = $urandom;
            end
            mem_dout_ready = (c == ready_at) || (junk && (c == 1 || c > exp_resp));
            mem_dout       = (c == ready_at) ? word : $urandom;
        end
        mem_dout_ready = 1'b0;
        req_valid      = 1'b0;

        chk({tag, ":strobes"}, 32'(n_strobe), 32'(exp_strobe));
        if (exp_strobe != 0) begin
            chk({tag, ":strobe_cyc"}, 32'(strobe_cyc), 32'd1);
            chk({tag, ":mem_we"},     32'(s_we), 32'(we));
            chk({tag, ":mem_rd"},     32'(s_rd), 32'(!we));
            chk({tag, ":mem_ctrl"},   32'(o_ctrl), 32'(exp_ctrl));
            chk({tag, ":mem_addr"},   o_maddr, {addr[31:2], 2'b00});
            if (we) chk({tag, ":mem_di"}, o_di, exp_di);
        end
        chk({tag, ":resp_count"}, 32'(n_resp), 32'd1);
        chk({tag, ":resp_cyc"},   32'(resp_cyc), 32'(exp_resp));
        chk({tag, ":rdata"},      o_rdata, exp_rdata);
        chk({tag, ":err"},        32'(o_err), 32'(exp_err));
        chk({tag, ":req_ready"},  32'(rr_bad), 32'd0);

        if (we && legal && !trap)
            for (int i = 0; i < size; i++)
                mem_b[ea[5:0] + 6'(i)] = 8'(wd >> (8 * i));
    endtask

    initial begin
        logic [31:0] rd, di, ma;
        logic [3:0]  ctrl;
        int          seen, w;

        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_dout = '0; mem_dout_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset:req_ready",  32'(req_ready), 32'd1);
        chk("reset:resp_valid", 32'(resp_valid), 32'd0);
        chk("reset:resp_err",   32'(resp_err), 32'd0);
        chk("reset:resp_rdata", resp_rdata, 32'd0);
        chk("reset:mem_we",     32'(mem_we), 32'd0);
        chk("reset:mem_rd",     32'(mem_rd), 32'd0);
        chk("reset:mem_ctrl",   32'(mem_ctrl), 32'd0);
        chk("reset:mem_addr",   mem_addr, 32'd0);
        chk("reset:mem_di",     mem_di, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: SW
        run_op(1'b1, 3'b010, 32'h10, 32'hCAFEBABE, 0, 1'b0, "t1_sw", rd, ctrl, di, ma);
        chk("t1:ctrl", 32'(ctrl), 32'hF);
        chk("t1:addr", ma, 32'h10);
        chk("t1:di",   di, 32'hCAFEBABE);

        // 2: SB then LB/LBU on the top byte
        run_op(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, 1'b0, "t2_sb", rd, ctrl, di, ma);
        chk("t2:ctrl", 32'(ctrl), 32'h8);
        chk("t2:di",   di, 32'hA5A5A5A5);
        run_op(1'b0, 3'b000, 32'h13, 32'h0, 1, 1'b0, "t2_lb", rd, ctrl, di, ma);
        chk("t2:lb", rd, 32'hFFFFFFA5);
        run_op(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0, "t2_lbu", rd, ctrl, di, ma);
        chk("t2:lbu", rd, 32'h000000A5);

        // 3: SH then LH/LHU on the upper half
        run_op(1'b1, 3'b001, 32'h12, 32'h12348001, 0, 1'b0, "t3_sh", rd, ctrl, di, ma);
        chk("t3:sh_di", di, 32'h80018001);
        run_op(1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, "t3_lh", rd, ctrl, di, ma);
        chk("t3:ctrl", 32'(ctrl), 32'hC);
        chk("t3:lh", rd, 32'hFFFF8001);
        run_op(1'b0, 3'b101, 32'h12, 32'h0, 0, 1'b0, "t3_lhu", rd, ctrl, di, ma);
        chk("t3:lhu", rd, 32'h00008001);

        // 4: timeout (late ready lands in RESP and must be dropped), then a normal LW
        run_op(1'b0, 3'b010, 32'h10, 32'h0, TMO, 1'b0, "t4_tmo", rd, ctrl, di, ma);
        chk("t4:tmo_rdata", rd, 32'h0);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, TMO - 1, 1'b0, "t4_last", rd, ctrl, di, ma);
        chk("t4:last_cycle_rdata", rd, 32'h8001BABE);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, "t4_lw", rd, ctrl, di, ma);
        chk("t4:lw", rd, 32'h8001BABE);

        // 5: misaligned LW
        run_op(1'b0, 3'b010, 32'h11, 32'h0, 1, 1'b0, "t5_mis", rd, ctrl, di, ma);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("t5:trap_rdata", rd, 32'h0);
`else
        chk("t5:addr", ma, 32'h10);
        chk("t5:lw",   rd, 32'h8001BABE);
`endif

        // 6: illegal funct3, busy poke, reset in WAIT
        run_op(1'b0, 3'b011, 32'h20, 32'h0, 0, 1'b0, "t6_ill_ld", rd, ctrl, di, ma);
        run_op(1'b1, 3'b101, 32'h20, 32'h1234, 0, 1'b0, "t6_ill_st", rd, ctrl, di, ma);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 4, 1'b1, "t6_poke", rd, ctrl, di, ma);

        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        mem_dout_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t6_rst:issue_rd", 32'(mem_rd), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst:req_ready",  32'(req_ready), 32'd1);
        chk("t6_rst:resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_rst:mem_rd",     32'(mem_rd), 32'd0);
        rst = 1'b0; mem_dout_ready = 1'b1; mem_dout = $urandom;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        mem_dout_ready = 1'b0;
        chk("t6_rst:no_resp", 32'(seen), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            bit          we;
            logic [2:0]  f3;
            int          k, r;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            k  = (r == 0) ? TMO : (r == 1) ? TMO - 1 : $urandom_range(0, 4);
            run_op(we, f3, $urandom, $urandom, k, ($urandom_range(0, 3) == 0), "rnd",
                   rd, ctrl, di, ma);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
